usb_in_ep_scheduler: RTL and testbench
======================================

// Module: usb_in_ep_scheduler
// PURPOSE
// - Shares the single 8-bit IN-endpoint write port of the IN protocol engine
//   between N_EP_IN byte-stream requesters, one requester per IN endpoint.
// - Grants requesters round-robin, one packet per grant, and drives per-endpoint
//   put/done strobes.
// - Closes short packets on end-of-message or on an idle-flush timeout.
// - Sits between the application streams (e.g. serial channels) and the IN PE.
// PARAMETERS
// - N_EP_IN             2     number of IN endpoints / requesters (1..16)
// - MAX_IN_PACKET_SIZE  32    PE buffer bytes per endpoint, in {8,16,32}
// - FLUSH_CYCLES        1024  idle cycles before a partial packet is closed (>=2)
// PORTS
// - i_clk            in   1            clock; single clock domain
// - i_rst            in   1            reset, asynchronous, active-high
// - i_req_valid      in   N_EP_IN      requester e has a byte
// - i_req_data       in   8*N_EP_IN    byte of requester e at [8e+7:8e]
// - i_req_last       in   N_EP_IN      byte is last of a message
// - o_req_ready      out  N_EP_IN      byte accepted when valid&&ready
// - i_inEp_dataFree  in   N_EP_IN      PE endpoint e is PUTTING and not full
// - o_inEp_dataPut   out  N_EP_IN      write strobe to PE (one-hot or zero)
// - o_inEp_data      out  8            write data to PE
// - o_inEp_dataDone  out  N_EP_IN      close current packet of endpoint e (pulse)
// - i_inEp_acked     in   N_EP_IN      PE packet of endpoint e ACKed by host
// - o_grant          out  N_EP_IN      one-hot current grant, 0 when idle
// - o_ackCount       out  16           total ACKed IN packets, wraps at 2^16
// BEHAVIOUR
// - Reset: state ARB_IDLE, rrPtr=0, pktCnt=0, idleTmr=0, ackCount=0.
//   All outputs are 0 while i_rst is high.
// - State: arb FSM {ARB_IDLE, ARB_FILL, ARB_CLOSE}, grant index g, rrPtr,
//   pktCnt[$clog2(MAX)+1], idleTmr[$clog2(FLUSH_CYCLES)+1].
// - Eligible e: i_req_valid[e] && i_inEp_dataFree[e].
// - ARB_IDLE: pick the first eligible e searching rrPtr, rrPtr+1, ... (mod N).
//   On a pick: g<=e, pktCnt<=0, idleTmr<=0, next ARB_FILL. No transfer this cycle.
// - ARB_FILL: o_req_ready[g] = i_inEp_dataFree[g] (combinational, same cycle).
//   Transfer = i_req_valid[g] && o_req_ready[g]. On a transfer:
//   o_inEp_dataPut[g]=1, o_inEp_data=i_req_data[g] (zero-latency mux),
//   pktCnt++, idleTmr<=0. With no transfer: idleTmr++, saturating.
// - ARB_FILL exits, in priority order:
//   1) transfer with i_req_last, and pktCnt+1 < MAX -> ARB_CLOSE
//   2) transfer with pktCnt+1 == MAX (last or not) -> ARB_IDLE; the PE
//      self-closes a full buffer; no dataDone.
//   3) i_inEp_dataFree[g]==0 (PE left PUTTING) -> ARB_IDLE
//   4) idleTmr==FLUSH_CYCLES-1 && pktCnt>0 -> ARB_CLOSE
//   5) idleTmr==FLUSH_CYCLES-1 && pktCnt==0 -> ARB_IDLE (no empty packet)
// - ARB_CLOSE: o_inEp_dataDone[g]=1 for exactly one cycle, next ARB_IDLE.
// - On every entry to ARB_IDLE from FILL or CLOSE: rrPtr <= (g+1) mod N.
//   This gives one packet per grant, so no requester starves.
// - o_grant = onehot(g) in ARB_FILL and ARB_CLOSE, else 0.
// - o_req_ready and o_inEp_dataPut are never asserted for an ungranted endpoint.
//   At most one bit of dataPut/dataDone is set per cycle.
// - o_ackCount += popcount(i_inEp_acked) each cycle; modulo-2^16 wrap.
// - Simultaneous valid&&last and dataFree falling in the same cycle: the
//   transfer still happens (dataFree was high), and exit rule 1/2 takes priority.
// - Reset mid-packet: FSM returns to idle immediately (async); no dataDone
//   issued. Requester bytes not yet accepted are retained by the requester.
// TESTING
// - N=2, ep0 sends 5 bytes with last on byte 5 -> 5 dataPut[0] pulses with data
//   matching, then a dataDone[0] pulse 1 cycle after byte 5; grant then 0.
// - ep0 sends 40 bytes continuously, MAX=32 -> 32 puts, no dataDone, release;
//   regrant only after dataFree[0] returns; remaining 8 bytes follow.
// - ep0 and ep1 both always valid -> grants alternate 0,1,0,1 per packet;
//   dataPut is never two-hot.
// - ep1 sends 3 bytes then goes idle, FLUSH_CYCLES=16 -> dataDone[1] exactly
//   16 cycles after the third byte.
// - Grant held with dataFree[0] forced low -> ready[0]=0, FSM returns to idle
//   the next cycle, rrPtr=1.
// - Assert i_rst mid-FILL -> outputs 0 asynchronously; ackCount=0; after
//   release, ackCount counts three acked pulses as 3.

Source files
------------

// File: rtl/usb_in_ep_scheduler.sv
// Round-robin arbiter sharing the PE IN-endpoint byte write port; one packet per grant.
// Zero-latency byte path (ready/put/data are combinational on the grant); dataDone one cycle after a closing byte.
module usb_in_ep_scheduler #(
   parameter int N_EP_IN            = 2,
   parameter int MAX_IN_PACKET_SIZE = 32,
   parameter int FLUSH_CYCLES       = 1024
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_EP_IN-1:0]     i_req_valid,
   input  logic [8*N_EP_IN-1:0]   i_req_data,
   input  logic [N_EP_IN-1:0]     i_req_last,
   output logic [N_EP_IN-1:0]     o_req_ready,
   input  logic [N_EP_IN-1:0]     i_inEp_dataFree,
   output logic [N_EP_IN-1:0]     o_inEp_dataPut,
   output logic [7:0]             o_inEp_data,
   output logic [N_EP_IN-1:0]     o_inEp_dataDone,
   input  logic [N_EP_IN-1:0]     i_inEp_acked,
   output logic [N_EP_IN-1:0]     o_grant,
   output logic [15:0]            o_ackCount
);

   localparam int IDX_W = (N_EP_IN > 1) ? $clog2(N_EP_IN) : 1;
   localparam int PKT_W = $clog2(MAX_IN_PACKET_SIZE) + 1;
   localparam int TMR_W = $clog2(FLUSH_CYCLES) + 1;
   localparam int CNT_W = $clog2(N_EP_IN + 1);

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_FILL,
      ARB_CLOSE
   } arb_state_e;

   arb_state_e           state_q;
   logic [IDX_W-1:0]     g_q;
   logic [IDX_W-1:0]     rr_q;
   logic [PKT_W-1:0]     pkt_q;
   logic [TMR_W-1:0]     tmr_q;
   logic [N_EP_IN-1:0]   grant_q;
   logic [N_EP_IN-1:0]   done_q;
   logic [15:0]          ack_q;

   logic [N_EP_IN-1:0]   elig_d;
   logic                 g_valid_d;
   logic                 g_last_d;
   logic                 g_free_d;
   logic [7:0]           g_data_d;
   logic                 xfer_d;
   logic [N_EP_IN-1:0]   ready_d;
   logic [N_EP_IN-1:0]   put_d;
   logic [7:0]           data_d;
   logic                 pick_vld_d;
   logic [IDX_W-1:0]     pick_idx_d;
   logic [IDX_W-1:0]     cand_d;
   logic [IDX_W-1:0]     g_next_d;
   logic [PKT_W-1:0]     pkt_inc_d;
   logic                 full_d;
   logic [TMR_W-1:0]     tmr_inc_d;
   logic                 timeout_d;
   logic [CNT_W-1:0]     acks_d;

   function automatic logic [N_EP_IN-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_EP_IN-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign elig_d = i_req_valid & i_inEp_dataFree;

   // Granted requester is muxed straight onto the PE port, no pipeline stage.
   always_comb begin
      g_valid_d = i_req_valid[g_q];
      g_last_d  = i_req_last[g_q];
      g_free_d  = i_inEp_dataFree[g_q];
      g_data_d  = i_req_data[{g_q, 3'b000} +: 8];
      xfer_d    = (state_q == ARB_FILL) && g_valid_d && g_free_d;
      ready_d   = '0;
      put_d     = '0;
      data_d    = 8'h00;
      if (state_q == ARB_FILL) begin
         ready_d[g_q] = g_free_d;
      end
      if (xfer_d) begin
         put_d[g_q] = 1'b1;
         data_d     = g_data_d;
      end
   end

   always_comb begin
      pick_vld_d = 1'b0;
      pick_idx_d = '0;
      cand_d     = '0;
      for (int k = 0; k < N_EP_IN; k++) begin
         cand_d = IDX_W'((int'(rr_q) + k) % N_EP_IN);
         if (!pick_vld_d && elig_d[cand_d]) begin
            pick_vld_d = 1'b1;
            pick_idx_d = cand_d;
         end
      end
   end

   assign g_next_d  = (int'(g_q) == N_EP_IN - 1) ? '0 : g_q + 1'b1;
   assign pkt_inc_d = pkt_q + 1'b1;
   assign full_d    = (pkt_inc_d == PKT_W'(MAX_IN_PACKET_SIZE));
   assign tmr_inc_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
   // The idle cycle that brings the timer to FLUSH_CYCLES-1 is the one that closes.
   assign timeout_d = (tmr_inc_d == TMR_W'(FLUSH_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
         g_q     <= '0;
         rr_q    <= '0;
         pkt_q   <= '0;
         tmr_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            ARB_IDLE: begin
               if (pick_vld_d) begin
                  g_q     <= pick_idx_d;
                  pkt_q   <= '0;
                  tmr_q   <= '0;
                  grant_q <= onehot(pick_idx_d);
                  state_q <= ARB_FILL;
               end
            end
            ARB_FILL: begin
               if (xfer_d) begin
                  pkt_q <= pkt_inc_d;
                  tmr_q <= '0;
                  if (g_last_d && !full_d) begin
                     done_q  <= onehot(g_q);
                     state_q <= ARB_CLOSE;
                  end else if (full_d) begin
                     // PE closes a full buffer itself, so no dataDone here.
                     grant_q <= '0;
                     rr_q    <= g_next_d;
                     state_q <= ARB_IDLE;
                  end
               end else begin
                  tmr_q <= tmr_inc_d;
                  if (!g_free_d) begin
                     grant_q <= '0;
                     rr_q    <= g_next_d;
                     state_q <= ARB_IDLE;
                  end else if (timeout_d && (pkt_q != '0)) begin
                     done_q  <= onehot(g_q);
                     state_q <= ARB_CLOSE;
                  end else if (timeout_d) begin
                     grant_q <= '0;
                     rr_q    <= g_next_d;
                     state_q <= ARB_IDLE;
                  end
               end
            end
            ARB_CLOSE: begin
               grant_q <= '0;
               rr_q    <= g_next_d;
               state_q <= ARB_IDLE;
            end
            default: begin
               grant_q <= '0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      acks_d = '0;
      for (int k = 0; k < N_EP_IN; k++) begin
         acks_d = acks_d + CNT_W'(i_inEp_acked[k]);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ack_q <= '0;
      end else begin
         ack_q <= ack_q + 16'(acks_d);
      end
   end

   assign o_req_ready     = ready_d;
   assign o_inEp_dataPut  = put_d;
   assign o_inEp_data     = data_d;
   assign o_inEp_dataDone = done_q;
   assign o_grant         = grant_q;
   assign o_ackCount      = ack_q;

endmodule

// File: tb/tb_usb_in_ep_scheduler.sv
// Scoreboard bench for usb_in_ep_scheduler: requester queues and a PE model drive the DUT,
// a negedge monitor pops expected put/done events; directed phases check timing corners.
module tb_usb_in_ep_scheduler;
   localparam int N     = 2;
   localparam int MAX   = 32;
   localparam int FLUSH = 16;
   localparam int BUSY  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_last, req_ready, free, put, done, acked, grant;
   logic [8*N-1:0] req_data;
   logic [7:0]     pe_data;
   logic [15:0]    ack_count;
   logic [N-1:0]   pe_free, hold_low, pe_ack, man_ack;

   assign free  = pe_free & ~hold_low;
   assign acked = pe_ack | man_ack;

   usb_in_ep_scheduler #(
      .N_EP_IN(N), .MAX_IN_PACKET_SIZE(MAX), .FLUSH_CYCLES(FLUSH)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
      .o_req_ready(req_ready),
      .i_inEp_dataFree(free), .o_inEp_dataPut(put), .o_inEp_data(pe_data),
      .o_inEp_dataDone(done), .i_inEp_acked(acked),
      .o_grant(grant), .o_ackCount(ack_count)
   );

   typedef struct { logic [7:0] d; logic l; } byte_t;
   typedef struct { logic is_done; int ep; logic [7:0] d; } ev_t;

   byte_t rq0[$];
   byte_t rq1[$];
   ev_t   exp_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int put_cnt = 0;
   int last_put_cyc = 0;
   int done_cyc = 0;
   int ack_model = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      if (rq0.size() > 0) begin
         req_valid[0]   = 1'b1;
         req_last[0]    = rq0[0].l;
         req_data[7:0]  = rq0[0].d;
      end
      if (rq1.size() > 0) begin
         req_valid[1]   = 1'b1;
         req_last[1]    = rq1[0].l;
         req_data[15:8] = rq1[0].d;
      end
   endtask

   task automatic send_msg(input int e, input int n, input logic [7:0] base, input logic last);
      byte_t b;
      for (int i = 0; i < n; i++) begin
         b.d = 8'(base + i);
         b.l = last && (i == n - 1);
         if (e == 0) rq0.push_back(b);
         else        rq1.push_back(b);
      end
      refresh();
   endtask

   task automatic expect_msg(input int e, input int n, input logic [7:0] base, input logic closed);
      ev_t ev;
      for (int i = 0; i < n; i++) begin
         ev.is_done = 1'b0;
         ev.ep      = e;
         ev.d       = 8'(base + i);
         exp_q.push_back(ev);
      end
      if (closed) begin
         ev.is_done = 1'b1;
         ev.ep      = e;
         ev.d       = 8'h00;
         exp_q.push_back(ev);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || rq0.size() > 0 || rq1.size() > 0) && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout with %0d events and %0d/%0d bytes pending, required 0",
                  name, exp_q.size(), rq0.size(), rq1.size());
         exp_q.delete();
         rq0.delete();
         rq1.delete();
         refresh();
      end
   endtask

   task automatic settle();
      repeat (BUSY + 4) @(posedge clk);
      #1;
   endtask

   // Requester side: bytes leave the queue only on a sampled valid && ready.
   initial begin
      logic [N-1:0] fire;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk); #1;
         if (fire[0]) void'(rq0.pop_front());
         if (fire[1]) void'(rq1.pop_front());
         refresh();
      end
   end

   // PE model: leaves PUTTING on a full buffer or a close, ACKs after BUSY cycles.
   initial begin
      logic [N-1:0] start;
      int cnt [N];
      int busy [N];
      pe_free = '1;
      pe_ack  = '0;
      forever begin
         @(negedge clk);
         start = '0;
         for (int e = 0; e < N; e++) begin
            if (put[e]) begin
               cnt[e]++;
               if (cnt[e] == MAX) begin
                  start[e] = 1'b1;
                  cnt[e]   = 0;
               end
            end
            if (done[e]) begin
               start[e] = 1'b1;
               cnt[e]   = 0;
            end
         end
         if (rst) ack_model = 0;
         else     ack_model += $countones(acked);
         @(posedge clk); #1;
         pe_ack = '0;
         for (int e = 0; e < N; e++) begin
            if (start[e]) begin
               busy[e]    = BUSY;
               pe_free[e] = 1'b0;
            end else if (busy[e] > 0) begin
               busy[e]--;
               if (busy[e] == 0) begin
                  pe_free[e] = 1'b1;
                  pe_ack[e]  = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: every put/done strobe is matched against the next expected event.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (req_ready != '0) check("ready_granted", 32'(req_ready & ~grant), 0);
            if (put != '0) begin
               check("put_onehot", 32'($onehot(put)), 1);
               check("put_granted", 32'(put & ~grant), 0);
               check("put_free", 32'(put & ~free), 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_put: got put=%b data=0x%0h, expected none", put, pe_data);
               end else begin
                  ev = exp_q.pop_front();
                  check("ev_kind_put", 32'(ev.is_done), 0);
                  check("ev_put_ep", 32'(put), 32'(1) << ev.ep);
                  check("ev_put_data", 32'(pe_data), 32'(ev.d));
               end
               put_cnt++;
               last_put_cyc = cyc;
            end
            if (done != '0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done=%b, expected none", done);
               end else begin
                  ev = exp_q.pop_front();
                  check("ev_kind_done", 32'(ev.is_done), 1);
                  check("ev_done_ep", 32'(done), 32'(1) << ev.ep);
               end
               done_cyc = cyc;
            end
         end
      end
   end

   initial begin
      int n;
      int pc0;
      rst      = 1'b1;
      hold_low = '0;
      man_ack  = '0;
      refresh();
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", 32'(grant), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_put", 32'(put), 0);
      check("rst_done", 32'(done), 0);
      check("rst_data", 32'(pe_data), 0);
      check("rst_ack", 32'(ack_count), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Short message closed by last; dataDone one cycle after the last byte.
      expect_msg(0, 5, 8'h10, 1'b1);
      send_msg(0, 5, 8'h10, 1'b1);
      wait_idle("p1_drain", 200);
      check("p1_done_latency", 32'(done_cyc - last_put_cyc), 1);
      @(negedge clk);
      check("p1_grant_released", 32'(grant), 0);
      settle();

      // 40 bytes: 32-byte full packet without dataDone, regrant after PE frees up.
      expect_msg(0, 40, 8'h40, 1'b1);
      send_msg(0, 40, 8'h40, 1'b1);
      pc0 = put_cnt;
      n = 0;
      while (put_cnt < pc0 + 32 && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      check("p2_32_puts_seen", 32'(n < 300), 1);
      @(negedge clk);
      check("p2_grant_after_full", 32'(grant), 0);
      check("p2_pe_not_free", 32'(free[0]), 0);
      @(negedge clk);
      check("p2_no_regrant_while_busy", 32'(grant), 0);
      wait_idle("p2_drain", 300);
      settle();

      // Both requesters busy: rrPtr is 1, so ep1 first, then strict alternation.
      expect_msg(1, 4, 8'h80, 1'b1);
      expect_msg(0, 4, 8'hA0, 1'b1);
      expect_msg(1, 4, 8'h90, 1'b1);
      expect_msg(0, 4, 8'hB0, 1'b1);
      send_msg(0, 4, 8'hA0, 1'b1);
      send_msg(0, 4, 8'hB0, 1'b1);
      send_msg(1, 4, 8'h80, 1'b1);
      send_msg(1, 4, 8'h90, 1'b1);
      wait_idle("p3_drain", 400);
      settle();

      // Partial packet closed by the idle flush timer.
      expect_msg(1, 3, 8'hC0, 1'b1);
      send_msg(1, 3, 8'hC0, 1'b0);
      wait_idle("p4_drain", 200);
      check("p4_flush_latency", 32'(done_cyc - last_put_cyc), FLUSH);
      settle();

      // Grant held while the PE drops dataFree: release next cycle, rrPtr moves to 1.
      expect_msg(1, 1, 8'hD1, 1'b1);
      expect_msg(0, 1, 8'hD0, 1'b1);
      send_msg(0, 1, 8'hD0, 1'b1);
      @(posedge clk); #1;
      hold_low[0] = 1'b1;
      @(negedge clk);
      check("p5_grant_held", 32'(grant), 32'h1);
      check("p5_ready_low", 32'(req_ready), 0);
      check("p5_no_put", 32'(put), 0);
      @(posedge clk); #1;
      hold_low[0] = 1'b0;
      send_msg(1, 1, 8'hD1, 1'b1);
      @(negedge clk);
      check("p5_back_to_idle", 32'(grant), 0);
      @(negedge clk);
      check("p5_rr_picks_ep1", 32'(grant), 32'h2);
      wait_idle("p5_drain", 200);
      settle();
      @(posedge clk); #2;
      check("ack_total_before_rst", 32'(ack_count), 10);
      check("ack_vs_model", 32'(ack_count), 32'(ack_model[15:0]));

      // Reset in the middle of a packet; remaining bytes follow as a fresh packet.
      expect_msg(0, 10, 8'hE0, 1'b1);
      send_msg(0, 10, 8'hE0, 1'b1);
      pc0 = put_cnt;
      n = 0;
      while (put_cnt < pc0 + 4 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      rst = 1'b1;
      #1;
      check("arst_grant", 32'(grant), 0);
      check("arst_ready", 32'(req_ready), 0);
      check("arst_put", 32'(put), 0);
      check("arst_done", 32'(done), 0);
      check("arst_ack", 32'(ack_count), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_idle("p6_drain", 300);
      settle();
      @(posedge clk); #2;
      check("ack_after_rst", 32'(ack_count), 1);

      @(posedge clk); #1; man_ack = 2'b01;
      @(posedge clk); #1; man_ack = 2'b10;
      @(posedge clk); #1; man_ack = 2'b01;
      @(posedge clk); #1; man_ack = 2'b00;
      @(posedge clk); #2;
      check("ack_three_pulses", 32'(ack_count), 4);
      @(posedge clk); #1; man_ack = 2'b11;
      @(posedge clk); #1; man_ack = 2'b00;
      @(posedge clk); #2;
      check("ack_popcount", 32'(ack_count), 6);
      check("ack_model_final", 32'(ack_count), 32'(ack_model[15:0]));
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
